// File: rtl/sha256_w_stream_reader_if.sv
// Handshake bundle between the block loader, the schedule reader and the round stage.
// The master view belongs to the schedule reader; the slave view belongs to its environment.
interface sha256_w_stream_reader_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;
    logic         busy;

    modport master (
        input  blk_valid, blk_in, w_ready,
        output blk_ready, w_valid, w_out, w_idx, w_last, busy
    );

    modport slave (
        output blk_valid, blk_in, w_ready,
        input  blk_ready, w_valid, w_out, w_idx, w_last, busy
    );
endinterface

// File: rtl/sha256_w_stream_reader.sv
// SHA-256 message schedule reader: loads one padded block and streams W_0..W_(ROUNDS-1)
// from a 16-word sliding window that is expanded on each accepted transfer.
module sha256_w_stream_reader #(
    parameter int ROUNDS = 64
) (
    input  logic                             CLK,
    input  logic                             RST,
    sha256_w_stream_reader_if.master         bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_e      state_q, state_d;
    logic [31:0] window_q [16];
    logic [31:0] window_d [16];
    logic [5:0]  count_q, count_d;
    logic        xfer_s;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

    // Next-state: block load in IDLE, window shift plus expansion on each RUN transfer.
    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        count_d  = count_q;
        xfer_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        window_d[i] = bus.blk_in[32*(15-i) +: 32];
                    end
                    count_d = 6'd0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                xfer_s = bus.w_ready;
                if (xfer_s) begin
                    for (int i = 0; i < 15; i++) begin
                        window_d[i] = window_q[i+1];
                    end
                    window_d[15] = sigma1(window_q[14]) + window_q[9]
                                 + sigma0(window_q[1]) + window_q[0];
                    // The final transfer returns count to zero instead of wrapping past the end.
                    if (count_q == LAST_IDX) begin
                        count_d = 6'd0;
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q + 6'd1;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, window and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            count_q <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            window_q <= window_d;
        end
    end

    assign bus.blk_ready = (state_q == ST_IDLE);
    assign bus.w_valid   = (state_q == ST_RUN);
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.w_out     = window_q[0];
    assign bus.w_idx     = count_q;
    assign bus.w_last    = (state_q == ST_RUN) && (count_q == LAST_IDX);

endmodule

// File: tb/tb_sha256_w_stream_reader.sv
// Scoreboard bench for the SHA-256 schedule reader: a 64-round instance and a 16-round instance.
module tb_sha256_w_stream_reader;

    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   abc_check = 1'b0;
    exp_t sb [$];
    logic [31:0] wm [64];

    localparam logic [511:0] ABC_BLK = {32'h6162_6380, 448'h0, 32'h0000_0018};

    always #5 clk = ~clk;

    sha256_w_stream_reader_if bus64 ();
    sha256_w_stream_reader_if bus16 ();

    sha256_w_stream_reader #(.ROUNDS(64)) dut64 (.CLK(clk), .RST(rst), .bus(bus64));
    sha256_w_stream_reader #(.ROUNDS(16)) dut16 (.CLK(clk), .RST(rst), .bus(bus16));

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reference schedule in array form; pushes the first n words to the scoreboard.
    task automatic build_model(input logic [511:0] blk, input int n);
        exp_t e;
        for (int t = 0; t < 16; t++) wm[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) wm[t] = ss1(wm[t-2]) + wm[t-7] + ss0(wm[t-15]) + wm[t-16];
        for (int t = 0; t < n; t++) begin
            e.w = wm[t];
            e.idx = 6'(t);
            e.last = (t == n - 1);
            sb.push_back(e);
        end
    endtask

    // Called at a negedge with the reader idle; returns at the negedge after the handshake.
    task automatic load64(input logic [511:0] blk);
        bus64.blk_in    = blk;
        bus64.blk_valid = 1'b1;
        bus64.w_ready   = 1'b0;
        checks++;
        if (bus64.blk_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_blk_ready: got %b want 1", bus64.blk_ready);
        end
        build_model(blk, 64);
        @(negedge clk);
    endtask

    task automatic drain64(input int mode, input bit hold_valid, output int xfers);
        exp_t        e;
        logic [31:0] pw;
        logic [5:0]  pi;
        logic        pl;
        bit          stalled;
        int          cyc;
        xfers = 0; stalled = 1'b0; cyc = 0; pw = 32'h0; pi = 6'h0; pl = 1'b0;
        if (!hold_valid) bus64.blk_valid = 1'b0;
        checks++;
        if (bus64.w_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_word_latency: w_valid=%b want 1", bus64.w_valid);
        end
        while (bus64.w_valid === 1'b1 && cyc < 400) begin
            checks++;
            if (bus64.blk_ready !== 1'b0 || bus64.busy !== 1'b1) begin
                failures++;
                $display("FAIL run_flags: blk_ready=%b busy=%b want 0/1", bus64.blk_ready, bus64.busy);
            end
            if (stalled) begin
                checks++;
                if ({bus64.w_out, bus64.w_idx, bus64.w_last} !== {pw, pi, pl}) begin
                    failures++;
                    $display("FAIL stall_hold: got %h/%0d/%b want %h/%0d/%b",
                             bus64.w_out, bus64.w_idx, bus64.w_last, pw, pi, pl);
                end
            end
            bus64.w_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (bus64.w_ready) begin
                stalled = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL extra_word: idx=%0d with empty scoreboard", bus64.w_idx);
                end else begin
                    e = sb.pop_front();
                    if ({bus64.w_out, bus64.w_idx, bus64.w_last} !== {e.w, e.idx, e.last}) begin
                        failures++;
                        $display("FAIL word: got %h/%0d/%b want %h/%0d/%b",
                                 bus64.w_out, bus64.w_idx, bus64.w_last, e.w, e.idx, e.last);
                    end
                end
                if (abc_check && (bus64.w_idx == 6'd16 || bus64.w_idx == 6'd17)) begin
                    checks++;
                    if (bus64.w_out !== ((bus64.w_idx == 6'd16) ? 32'h6162_6380 : 32'h000F_0000)) begin
                        failures++;
                        $display("FAIL abc_known_word: idx=%0d got %h", bus64.w_idx, bus64.w_out);
                    end
                end
                xfers++;
            end else begin
                stalled = 1'b1;
                pw = bus64.w_out; pi = bus64.w_idx; pl = bus64.w_last;
            end
            cyc++;
            @(negedge clk);
        end
        bus64.w_ready = 1'b0;
        checks++;
        if (cyc >= 400) begin
            failures++;
            $display("FAIL drain_timeout: %0d cycles", cyc);
        end
    endtask

    task automatic check_done(input string name, input int xfers, input int want);
        checks++;
        if (xfers != want || sb.size() != 0) begin
            failures++;
            $display("FAIL %s_count: transfers=%0d left=%0d want %0d/0", name, xfers, sb.size(), want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus64.blk_valid = 1'b1;
        bus64.blk_in = ABC_BLK;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus64.w_valid, bus64.busy, bus64.w_idx, bus64.w_last, bus64.w_out} !== 40'h0) begin
            failures++;
            $display("FAIL reset_outputs: w_valid=%b busy=%b idx=%0d last=%b w=%h want all 0",
                     bus64.w_valid, bus64.busy, bus64.w_idx, bus64.w_last, bus64.w_out);
        end
        rst = 1'b0;
        bus64.blk_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus64.blk_ready !== 1'b1 || bus64.w_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: blk_ready=%b w_valid=%b want 1/0", bus64.blk_ready, bus64.w_valid);
        end
    endtask

    task automatic test_abc;
        int x;
        abc_check = 1'b1;
        load64(ABC_BLK);
        drain64(0, 1'b0, x);
        abc_check = 1'b0;
        check_done("abc", x, 64);
    endtask

    task automatic test_backpressure;
        int x;
        load64(ABC_BLK);
        drain64(1, 1'b0, x);
        check_done("backpressure", x, 64);
    endtask

    task automatic test_back_to_back;
        int x;
        logic [511:0] blk_b;
        for (int i = 0; i < 16; i++) blk_b[32*i +: 32] = $urandom;
        load64(ABC_BLK);
        drain64(0, 1'b1, x);
        check_done("b2b_first", x, 64);
        load64(blk_b);
        drain64(0, 1'b0, x);
        check_done("b2b_second", x, 64);
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   cyc;
        int   x;
        logic [511:0] blk_c;
        for (int i = 0; i < 16; i++) blk_c[32*i +: 32] = $urandom;
        load64(ABC_BLK);
        bus64.blk_valid = 1'b0;
        cyc = 0;
        while (bus64.w_valid === 1'b1 && bus64.w_idx !== 6'd20 && cyc < 100) begin
            bus64.w_ready = 1'b1;
            e = sb.pop_front();
            checks++;
            if (bus64.w_out !== e.w || bus64.w_idx !== e.idx) begin
                failures++;
                $display("FAIL pre_abort_word: got %h/%0d want %h/%0d", bus64.w_out, bus64.w_idx, e.w, e.idx);
            end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (bus64.w_idx !== 6'd20 || bus64.w_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_reach_20: idx=%0d valid=%b want 20/1", bus64.w_idx, bus64.w_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus64.w_valid !== 1'b0 || bus64.busy !== 1'b0 || bus64.w_idx !== 6'd0) begin
            failures++;
            $display("FAIL abort_state: w_valid=%b busy=%b idx=%0d want 0/0/0",
                     bus64.w_valid, bus64.busy, bus64.w_idx);
        end
        rst = 1'b0;
        bus64.w_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (bus64.w_valid !== 1'b0 || bus64.blk_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle: w_valid=%b blk_ready=%b want 0/1", bus64.w_valid, bus64.blk_ready);
        end
        load64(blk_c);
        drain64(0, 1'b0, x);
        check_done("after_abort", x, 64);
    endtask

    task automatic test_rounds16;
        exp_t e;
        int   cyc;
        int   x;
        logic [511:0] blk_d;
        for (int i = 0; i < 16; i++) blk_d[32*i +: 32] = $urandom;
        bus16.blk_in = blk_d;
        bus16.blk_valid = 1'b1;
        bus16.w_ready = 1'b0;
        build_model(blk_d, 16);
        @(negedge clk);
        bus16.blk_valid = 1'b0;
        x = 0; cyc = 0;
        while (bus16.w_valid === 1'b1 && cyc < 100) begin
            bus16.w_ready = 1'b1;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL r16_extra_word: idx=%0d w=%h", bus16.w_idx, bus16.w_out);
            end else begin
                e = sb.pop_front();
                if ({bus16.w_out, bus16.w_idx, bus16.w_last} !== {e.w, e.idx, e.last}) begin
                    failures++;
                    $display("FAIL r16_word: got %h/%0d/%b want %h/%0d/%b",
                             bus16.w_out, bus16.w_idx, bus16.w_last, e.w, e.idx, e.last);
                end
            end
            x++; cyc++;
            @(negedge clk);
        end
        bus16.w_ready = 1'b0;
        check_done("r16", x, 16);
        repeat (3) @(negedge clk);
        checks++;
        if (bus16.w_valid !== 1'b0 || bus16.blk_ready !== 1'b1) begin
            failures++;
            $display("FAIL r16_idle: w_valid=%b blk_ready=%b want 0/1", bus16.w_valid, bus16.blk_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus64.blk_valid = 1'b0; bus64.blk_in = 512'h0; bus64.w_ready = 1'b0;
        bus16.blk_valid = 1'b0; bus16.blk_in = 512'h0; bus16.w_ready = 1'b0;
        test_reset();
        test_abc();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_rounds16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
